// File: rtl/regfile_pkg.sv
// Shared types and constants for the 32-entry register file write side.
package regfile_pkg;

    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned DATA_W   = 64;
    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_wr_port_decoder5_32.sv
// 5-to-32 one-hot decoder; all zero when disabled.
module decoder5_32 (
    input  logic        en,
    input  logic [4:0]  addr,
    output logic [31:0] out
);

    always_comb begin
        out = '0;
        if (en) begin
            out[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_wr_port.sv
// Register file write port: valid/ready writeback FIFO draining one entry per cycle.
// Optional bypass lookup of pending writes is built when REGFILE_WR_BYPASS_EN is defined.
module regfile_wr_port
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ADDR_W-1:0]   in_addr,
    input  logic [WIDTH-1:0]    in_data,
    input  logic                rf_stall,
    output logic [NUM_REGS-1:0] wr_en,
    output logic [WIDTH-1:0]    wr_data,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic                fwd_hit,
    output logic [WIDTH-1:0]    fwd_data,
    output logic                busy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wb_entry_t          mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    wb_entry_t          head;
    logic               push;
    logic               pop;
    logic               dec_en;

    assign head     = mem[rd_ptr];
    assign in_ready = (count < CNT_W'(DEPTH));
    assign busy     = (count != '0);
    assign push     = in_valid && in_ready;
    assign pop      = busy && !rf_stall;
    assign dec_en   = pop && (head.addr != ZERO_REG);
    assign wr_data  = busy ? WIDTH'(head.data) : '0;

    // Pointers wrap naturally since DEPTH is a power of two; count disambiguates full/empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= PTR_W'(wr_ptr + PTR_W'(1));
            end
            if (pop) begin
                rd_ptr <= PTR_W'(rd_ptr + PTR_W'(1));
            end
            case ({push, pop})
                2'b10:   count <= CNT_W'(count + CNT_W'(1));
                2'b01:   count <= CNT_W'(count - CNT_W'(1));
                default: count <= count;
            endcase
        end
    end

    // Entry storage needs no reset: contents are only observed while counted valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{addr: in_addr, data: DATA_W'(in_data)};
        end
    end

    decoder5_32 u_dec (
        .en   (dec_en),
        .addr (head.addr),
        .out  (wr_en)
    );

`ifdef REGFILE_WR_BYPASS_EN
    // Walk oldest to youngest so the youngest match overrides older ones.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < count) && (rd_addr != ZERO_REG) &&
                (mem[PTR_W'(rd_ptr + PTR_W'(i))].addr == rd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = WIDTH'(mem[PTR_W'(rd_ptr + PTR_W'(i))].data);
            end
        end
    end
`else
    logic bypass_unused;
    assign bypass_unused = ^rd_addr;
    assign fwd_hit       = 1'b0;
    assign fwd_data      = '0;
`endif

endmodule

// File: doc/regfile_wr_port.md
# regfile_wr_port

Write side of the 32-entry register file: the decode counterpart of the 32:1 read-select path. Accepts writeback requests on a valid/ready handshake and buffers them in a small FIFO. Drains one entry per cycle into the register array as a one-hot 32-bit write-enable plus data. Optionally exposes a bypass lookup so the read side can see writes that are still pending.

## Interface
- `WIDTH`, 64: register data width in bits.
- `DEPTH`, 2: FIFO entries; power of two, at least 2.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `in_valid` input 1: a writeback request is present.
- `in_ready` output 1: FIFO can accept a request this cycle.
- `in_addr` input 5: destination register number.
- `in_data` input WIDTH: value to write.
- `rf_stall` input 1: register array cannot take a write this cycle.
- `wr_en` output 32: one-hot write enable to the register array; all zero when no write occurs.
- `wr_data` output WIDTH: write data, qualified by `wr_en`.
- `rd_addr` input 5: address probed by the read side for bypass.
- `fwd_hit` output 1: a pending entry matches `rd_addr`.
- `fwd_data` output WIDTH: data from the youngest matching entry.
- `busy` output 1: FIFO is non-empty.

## Operation
- Push occurs when `in_valid && in_ready`. `in_ready = (count < DEPTH)`.
- While full, `in_ready` is 0 even if a pop happens in the same cycle. There is no same-cycle pass-through.
- Pop occurs when `count > 0 && !rf_stall`. In that cycle:
  - `wr_data` carries the head entry's data.
  - `wr_en` is the decoded head address.
- If the head address is 31 (zero register), the entry is popped but `wr_en` stays all zero.
- When no pop occurs, `wr_en` is all zero. `wr_data` is don't-care but driven as the head data, or 0 when empty.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. Count is tracked separately, `$clog2(DEPTH)+1` bits, so full and empty are never ambiguous.
- Bypass lookup:
  - Scans valid entries from youngest to oldest.
  - `fwd_hit` = 1 on the first entry with `addr == rd_addr` and `rd_addr != 31`.
  - `fwd_data` = that entry's data; 0 when there is no hit.
  - The entry being popped in the current cycle still participates.
  - The incoming, not-yet-pushed request does not participate.
- `busy = (count != 0)`.

## Timing
- Reset values: count 0, both pointers 0, `in_ready` 1, `wr_en` 0, `wr_data` 0, `fwd_hit` 0, `fwd_data` 0, `busy` 0.
- Reset asserted mid-operation discards all pending entries immediately, asynchronously.
- Latency from accepted push to `wr_en` asserted is 1 cycle minimum, when the FIFO was empty and `rf_stall` is low. Each older entry ahead in the FIFO adds 1 cycle, and each stalled cycle adds 1.
- Throughput: one write per cycle sustained.
- `wr_en`, `wr_data`, `in_ready`, `busy`, `fwd_hit` and `fwd_data` are combinational from registered state and `rf_stall`/`rd_addr`. None depend on `in_valid`.
- The register array samples `wr_en`/`wr_data` on the same `clk` edge that performs the pop.

## Configuration
- `REGFILE_WR_BYPASS_EN` defined: the bypass comparator and priority-select logic are built as described in Operation.
- `REGFILE_WR_BYPASS_EN` undefined: no comparators are built; `fwd_hit` is tied 0 and `fwd_data` tied 0. All other behaviour is identical.

## Structure
- Shared package `regfile_pkg`:
  - `NUM_REGS = 32`, `ADDR_W = 5`, `ZERO_REG = 5'd31`.
  - `wb_entry_t`, a packed struct of `addr[ADDR_W-1:0]` and `data[WIDTH-1:0]`. WIDTH is fixed at 64 in the package.
- Sub-module `decoder5_32`:
  - Inputs: `en`, `addr[4:0]`. Output: `out[31:0]`, one-hot when `en` is 1, else 0.
  - Instantiated once, with `en = pop && (head.addr != ZERO_REG)`.

## Test plan
- Reset with FIFO holding 2 entries → all outputs at reset values, `in_ready` = 1, no `wr_en` pulse after release.
- Push addr 5, data 0xDEAD_BEEF into an empty FIFO, `rf_stall` = 0 → next cycle `wr_en` = 0x0000_0020, `wr_data` = 0xDEAD_BEEF, `busy` falls the cycle after.
- Push addr 31, data 0x1234 → entry pops in 1 cycle with `wr_en` = 0 throughout. With bypass enabled, `rd_addr` = 31 gives `fwd_hit` = 0.
- Hold `rf_stall` = 1 and push addr 3 then addr 4 → `in_ready` = 0 after the second push and a third `in_valid` is not accepted. Release the stall → `wr_en` = 0x8, then 0x10, on consecutive cycles.
- With `REGFILE_WR_BYPASS_EN`: stall, push addr 7 data 0xA then addr 7 data 0xB, `rd_addr` = 7 → `fwd_hit` = 1, `fwd_data` = 0xB. Without the macro, `fwd_hit` = 0.
- Back-to-back pushes every cycle (addrs 0..9) with `rf_stall` = 0 → one `wr_en` per cycle in order, `in_ready` never drops, no entry lost or duplicated across pointer wrap.
